multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Control FSM for the multicycle RV32I core variant: sequences fetch, decode, execute, memory and writeback over several cycles on a shared ALU and a single unified memory port. It replaces the single-cycle opcode decoder in that variant, emitting per-state datapath selects and write enables. It waits on the memory port's ready handshake and traps illegal opcodes.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register (IR); valid from DECODE onward.
- zero  in  1  ALU zero flag, same cycle.
- mem_ready  in  1  memory port has completed the current access this cycle.
- pc_write  out  1  PC register load enable.
- adr_src  out  1  memory address select: 0=PC, 1=ALU result register.
- ir_write  out  1  IR/old-PC register load enable.
- mem_write  out  1  memory write strobe.
- reg_write  out  1  register-file write enable.
- result_src  out  2  result mux: 00=ALU result register, 01=data register, 10=ALU output.
- alu_src_a  out  2  ALU A: 00=PC, 01=old PC, 10=rs1 register.
- alu_src_b  out  2  ALU B: 00=rs2 register, 01=immediate, 10=constant 4.
- alu_op  out  2  to ALU decoder: 00=add, 01=subtract (branch), 10=funct-decoded.
- imm_src  out  2  immediate format: 00=I, 01=S, 10=B, 11=J.
- illegal_instr  out  1  high while in TRAP.

## Operation
- Moore FSM; all outputs are combinational from state, except that pc_write, ir_write and imm_src also depend on inputs as stated below. Unlisted outputs are 0.
- States and outputs:
  - FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write=mem_ready, pc_update=mem_ready. Stays in FETCH while !mem_ready; otherwise goes to DECODE.
  - DECODE: a=01, b=01, alu_op=00 (branch target precomputed). Next state by opcode:
    - 0000011, 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - anything else -> TRAP
  - MEMADR: a=10, b=01, alu_op=00. Next is MEMREAD for a load, MEMWRITE for a store.
  - MEMREAD: adr_src=1. Holds until mem_ready, then MEMWB.
  - MEMWB: result_src=01, reg_write=1. Next is FETCH.
  - MEMWRITE: adr_src=1, mem_write=1. Holds until mem_ready, then FETCH; mem_write stays high for every waiting cycle.
  - EXECUTER: a=10, b=00, alu_op=10. Next is ALUWB.
  - EXECUTEI: a=10, b=01, alu_op=10. Next is ALUWB.
  - ALUWB: result_src=00, reg_write=1. Next is FETCH.
  - BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1. Next is FETCH.
  - JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Next is ALUWB.
  - TRAP: illegal_instr=1, all write enables 0. Sticky; only reset leaves it.
- pc_write = pc_update | (branch & zero).
- imm_src is decoded from opcode in every state: store->01, branch->10, jal->11, otherwise 00.

## Timing
- Reset: state is forced to FETCH asynchronously. While rst is high, pc_write, ir_write, mem_write and reg_write are forced to 0; the other outputs take their FETCH values and illegal_instr=0.
- First fetch may complete on the first rising edge after rst deasserts, if mem_ready=1.
- Latency with mem_ready tied high:
  - R-type, I-type and store: 4 cycles.
  - Load: 5 cycles.
  - Branch: 3 cycles.
  - JAL: 4 cycles.
- Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. mem_ready is ignored in every other state.
- Reset asserted mid-instruction abandons it immediately; no partial write occurs after the asserting edge.
- In BEQ, zero is sampled combinationally in the same cycle. pc_write is high in that cycle only if zero=1.

## Configuration
- MC_JAL_EN defined: JAL state present; opcode 1101111 is legal, as above.
- MC_JAL_EN undefined: JAL state is absent and 1101111 decodes to TRAP. imm_src still reports 11 for that opcode.

## Structure
- Shared package riscv_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL);
  - the mc_state_t enum;
  - the encoding localparams for result_src, alu_src_a, alu_src_b, alu_op and imm_src.
- One sub-module, imm_src_decoder: a combinational opcode to imm_src map, reusable by the single-cycle core.

## Test plan
- Reset then add (0110011), mem_ready=1: states FETCH, DECODE, EXECUTER, ALUWB. reg_write=1 only in cycle 4; ir_write and pc_write=1 only in cycle 1.
- Load (0000011) with mem_ready low for 2 cycles in MEMREAD: 7 cycles total. adr_src=1 throughout MEMREAD; reg_write=1 with result_src=01 in the final cycle.
- Store (0100011) with mem_ready low for 1 cycle: mem_write=1 for 2 consecutive cycles, then FETCH; reg_write never asserted; imm_src=01.
- Branch (1100011) run twice:
  - zero=1: pc_write=1 in the BEQ cycle with alu_op=01.
  - zero=0: pc_write=0 in that cycle.
  - Both return to FETCH after 3 cycles.
- Opcode 0000000: TRAP after DECODE, illegal_instr=1 and all enables 0 for 10 cycles. Asserting rst returns to FETCH with illegal_instr=0.
- Opcode 1101111:
  - With MC_JAL_EN: FETCH, DECODE, JAL (pc_write=1), ALUWB (reg_write=1).
  - Without MC_JAL_EN: TRAP.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, multicycle controller states and datapath select encodings.
// The JAL state exists only when MC_JAL_EN is defined.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ,
    S_TRAP
`ifdef MC_JAL_EN
    , S_JAL
`endif
  } mc_state_t;

  localparam logic [1:0] RES_ALUREG = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALUOUT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/imm_src_decoder.sv
// Opcode to immediate-format map; shared with the single-cycle core.
// JAL always reports the J format, independent of MC_JAL_EN.
module imm_src_decoder
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  output logic [1:0] o_imm_src
);

  always_comb begin
    o_imm_src = IMM_I;
    case (i_opcode)
      OP_STORE:  o_imm_src = IMM_S;
      OP_BRANCH: o_imm_src = IMM_B;
      OP_JAL:    o_imm_src = IMM_J;
      default:   o_imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing with illegal-opcode trap.
// Define MC_JAL_EN to include the JAL state; otherwise JAL traps as illegal.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic       illegal_instr
);

  mc_state_t r_state;
  mc_state_t w_next;

  logic w_pc_update;
  logic w_branch;
  logic w_ir_write;
  logic w_mem_write;
  logic w_reg_write;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_pc_update   = 1'b0;
    w_branch      = 1'b0;
    w_ir_write    = 1'b0;
    w_mem_write   = 1'b0;
    w_reg_write   = 1'b0;
    adr_src       = 1'b0;
    result_src    = RES_ALUREG;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_RS2;
    alu_op        = ALUOP_ADD;
    illegal_instr = 1'b0;

    case (r_state)
      S_FETCH: begin
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_FOUR;
        result_src  = RES_ALUOUT;
        w_ir_write  = mem_ready;
        w_pc_update = mem_ready;
        w_next      = mem_ready ? S_DECODE : S_FETCH;
      end
      // Branch target is precomputed here from the old PC and the immediate.
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        case (opcode)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = S_EXECUTER;
          OP_I:              w_next = S_EXECUTEI;
          OP_BRANCH:         w_next = S_BEQ;
`ifdef MC_JAL_EN
          OP_JAL:            w_next = S_JAL;
`endif
          default:           w_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        w_next    = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        w_next  = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        result_src  = RES_DATA;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        w_mem_write = 1'b1;
        w_next      = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTER: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_RS2;
        alu_op    = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_EXECUTEI: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        result_src  = RES_ALUREG;
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RS1;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUREG;
        w_branch   = 1'b1;
        w_next     = S_FETCH;
      end
`ifdef MC_JAL_EN
      // Jump target was computed in DECODE; ALU now forms the link address.
      S_JAL: begin
        alu_src_a   = SRCA_OLDPC;
        alu_src_b   = SRCB_FOUR;
        alu_op      = ALUOP_ADD;
        result_src  = RES_ALUREG;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
`endif
      S_TRAP: begin
        illegal_instr = 1'b1;
        w_next        = S_TRAP;
      end
      default: begin
        w_next = S_FETCH;
      end
    endcase
  end

  // Enables are gated by rst so no write can slip through while reset is held.
  assign pc_write  = ~rst & (w_pc_update | (w_branch & zero));
  assign ir_write  = ~rst & w_ir_write;
  assign mem_write = ~rst & w_mem_write;
  assign reg_write = ~rst & w_reg_write;

  imm_src_decoder u_imm_src_decoder (
    .i_opcode  (opcode),
    .o_imm_src (imm_src)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle vectors, expected outputs queued, monitor compares.
// Honours MC_JAL_EN the same way as the design.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] opcode = 7'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .ir_write      (ir_write),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .result_src    (result_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .imm_src       (imm_src),
    .illegal_instr (illegal_instr)
  );

  typedef enum {T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE,
                T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_JAL, T_TRAP} tst_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  localparam logic [6:0] ADD = 7'b0110011, ADDI = 7'b0010011, LW = 7'b0000011,
                         SW = 7'b0100011, BEQ = 7'b1100011, JAL = 7'b1101111;

  // Packed order: pcw adr irw mw rw res[2] a[2] b[2] aluop[2] imm[2] ill
  function automatic logic [15:0] exp_out(tst_t st, logic [6:0] op, logic z, logic mr);
    logic pcw, adr, irw, mw, rw, ill;
    logic [1:0] res, a, b, aop, imm;
    pcw = 0; adr = 0; irw = 0; mw = 0; rw = 0; ill = 0;
    res = 2'b00; a = 2'b00; b = 2'b00; aop = 2'b00;
    imm = (op == SW) ? 2'b01 : (op == BEQ) ? 2'b10 : (op == JAL) ? 2'b11 : 2'b00;
    case (st)
      T_RST:      begin b = 2'b10; res = 2'b10; end
      T_FETCH:    begin b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
      T_DECODE:   begin a = 2'b01; b = 2'b01; end
      T_MEMADR:   begin a = 2'b10; b = 2'b01; end
      T_MEMREAD:  adr = 1;
      T_MEMWB:    begin res = 2'b01; rw = 1; end
      T_MEMWRITE: begin adr = 1; mw = 1; end
      T_EXECR:    begin a = 2'b10; b = 2'b00; aop = 2'b10; end
      T_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
      T_ALUWB:    rw = 1;
      T_BEQ:      begin a = 2'b10; aop = 2'b01; pcw = z; end
      T_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
      T_TRAP:     ill = 1;
      default:    ;
    endcase
    return {pcw, adr, irw, mw, rw, res, a, b, aop, imm, ill};
  endfunction

  task automatic step(string nm, tst_t st, logic [6:0] op, logic z, logic mr);
    exp_t e;
    @(posedge clk);
    #1;
    rst       = (st == T_RST);
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    e.name = nm;
    e.exp  = exp_out(st, op, z, mr);
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [15:0] act;
      e = q.pop_front();
      act = {pc_write, adr_src, ir_write, mem_write, reg_write, result_src,
             alu_src_a, alu_src_b, alu_op, imm_src, illegal_instr};
      n_chk++;
      if (act !== e.exp) begin
        n_err++;
        $display("FAIL %s got=%b want=%b", e.name, act, e.exp);
      end
    end
  end

  initial begin
    step("reset0", T_RST, 7'b0, 0, 1);
    step("reset1", T_RST, 7'b0, 0, 1);

    step("add.fetch",  T_FETCH,  ADD, 0, 1);
    step("add.decode", T_DECODE, ADD, 0, 1);
    step("add.exec",   T_EXECR,  ADD, 0, 1);
    step("add.wb",     T_ALUWB,  ADD, 0, 1);

    step("lw.fetch",   T_FETCH,   LW, 0, 1);
    step("lw.decode",  T_DECODE,  LW, 0, 1);
    step("lw.memadr",  T_MEMADR,  LW, 0, 1);
    step("lw.wait1",   T_MEMREAD, LW, 0, 0);
    step("lw.wait2",   T_MEMREAD, LW, 0, 0);
    step("lw.read",    T_MEMREAD, LW, 0, 1);
    step("lw.wb",      T_MEMWB,   LW, 0, 1);

    step("sw.fetch",   T_FETCH,    SW, 0, 1);
    step("sw.decode",  T_DECODE,   SW, 0, 0);
    step("sw.memadr",  T_MEMADR,   SW, 0, 0);
    step("sw.wait",    T_MEMWRITE, SW, 0, 0);
    step("sw.write",   T_MEMWRITE, SW, 0, 1);

    step("addi.fstall", T_FETCH,  ADDI, 0, 0);
    step("addi.fetch",  T_FETCH,  ADDI, 0, 1);
    step("addi.decode", T_DECODE, ADDI, 0, 1);
    step("addi.exec",   T_EXECI,  ADDI, 0, 1);
    step("addi.wb",     T_ALUWB,  ADDI, 0, 1);

    step("beqt.fetch",  T_FETCH,  BEQ, 1, 1);
    step("beqt.decode", T_DECODE, BEQ, 1, 1);
    step("beqt.beq",    T_BEQ,    BEQ, 1, 1);
    step("beqn.fetch",  T_FETCH,  BEQ, 0, 1);
    step("beqn.decode", T_DECODE, BEQ, 0, 0);
    step("beqn.beq",    T_BEQ,    BEQ, 0, 0);

    step("swrst.fetch",  T_FETCH,    SW, 0, 1);
    step("swrst.decode", T_DECODE,   SW, 0, 1);
    step("swrst.memadr", T_MEMADR,   SW, 0, 1);
    step("swrst.wait",   T_MEMWRITE, SW, 0, 0);
    step("swrst.rst",    T_RST,      SW, 0, 1);
    step("swrst.after",  T_FETCH,    ADD, 0, 0);

`ifdef MC_JAL_EN
    step("jal.fetch",  T_FETCH,  JAL, 0, 1);
    step("jal.decode", T_DECODE, JAL, 0, 1);
    step("jal.jal",    T_JAL,    JAL, 0, 1);
    step("jal.wb",     T_ALUWB,  JAL, 0, 1);
`else
    step("jal.fetch",  T_FETCH,  JAL, 0, 1);
    step("jal.decode", T_DECODE, JAL, 0, 1);
    step("jal.trap",   T_TRAP,   JAL, 0, 1);
    step("jal.rst",    T_RST,    JAL, 0, 1);
`endif

    step("ill.fetch",  T_FETCH,  7'b0000000, 0, 1);
    step("ill.decode", T_DECODE, 7'b0000000, 0, 1);
    for (int i = 0; i < 10; i++)
      step($sformatf("ill.trap%0d", i), T_TRAP, 7'b0000000, i[0], i[1]);
    step("ill.rst",    T_RST,   7'b0000000, 0, 1);
    step("ill.fetch2", T_FETCH, ADD, 0, 0);

    repeat (3) @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d want=0 pending", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
